// File: rtl/matmul_operand_loader.sv
// Operand loader for the MATMUL systolic stage: takes A (m x n) then B (n x p) as a
// row-major element stream and writes them into skewed, zero-padded register arrays.
module matmul_operand_loader #(
  parameter int BITS = 8,
  parameter int DIM  = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [$clog2(DIM):0]                       m,
  input  logic [$clog2(DIM):0]                       n,
  input  logic [$clog2(DIM):0]                       p,
  input  logic [BITS-1:0]                            in_data,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [DIM-1:0][DIM*2-2:0][BITS-1:0]        matrixDataA,
  output logic [DIM*2-2:0][DIM-1:0][BITS-1:0]        matrixDataB,
  output logic                                       ops_valid,
  input  logic                                       consumed,
  output logic                                       busy,
  output logic                                       err
);

  localparam int CW = $clog2(DIM) + 1;

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_t;

  state_t        state;
  state_t        nextState;
  logic [CW-1:0] mLat;
  logic [CW-1:0] nLat;
  logic [CW-1:0] pLat;
  logic [CW-1:0] rowCnt;
  logic [CW-1:0] colCnt;
  logic [CW-1:0] diagIdx;
  logic          dimsOk;
  logic          startOk;
  logic          accept;
  logic          rowEnd;
  logic          lastA;
  logic          lastB;

  // rowCnt is r (A) or k (B); colCnt is c (A) or j (B)
  always_comb begin
    dimsOk  = (m != '0) && (n != '0) && (p != '0) &&
              (m <= CW'(DIM)) && (n <= CW'(DIM)) && (p <= CW'(DIM));
    startOk = (state == IDLE) && start && dimsOk;
    accept  = in_ready && in_valid;
    diagIdx = rowCnt + colCnt;
    rowEnd  = (state == LOAD_A) ? (colCnt == nLat - CW'(1)) : (colCnt == pLat - CW'(1));
    lastA   = (state == LOAD_A) && accept && (colCnt == nLat - CW'(1)) &&
              (rowCnt == mLat - CW'(1));
    lastB   = (state == LOAD_B) && accept && (colCnt == pLat - CW'(1)) &&
              (rowCnt == nLat - CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (startOk) nextState = LOAD_A;
      LOAD_A:  if (lastA) nextState = LOAD_B;
      LOAD_B:  if (lastB) nextState = HOLD;
      HOLD:    if (consumed) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD_A) || (state == LOAD_B);
    ops_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mLat   <= '0;
      nLat   <= '0;
      pLat   <= '0;
      rowCnt <= '0;
      colCnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && !dimsOk;
      if (startOk) begin
        mLat   <= m;
        nLat   <= n;
        pLat   <= p;
        rowCnt <= '0;
        colCnt <= '0;
      end else if (accept) begin
        if (rowEnd) begin
          colCnt <= '0;
          rowCnt <= (lastA || lastB) ? '0 : rowCnt + CW'(1);
        end else begin
          colCnt <= colCnt + CW'(1);
        end
      end
    end
  end

  // Arrays are wiped by reset or an accepted start so no stale operand survives
  always_ff @(posedge clk) begin
    if (rst || startOk) begin
      matrixDataA <= '0;
      matrixDataB <= '0;
    end else if (accept) begin
      if (state == LOAD_A) matrixDataA[rowCnt[CW-2:0]][diagIdx] <= in_data;
      else                 matrixDataB[diagIdx][colCnt[CW-2:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Bench for matmul_operand_loader: random element streams compared against a
// row-major index model of the skewed A/B layouts.
module tb_matmul_operand_loader;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic [5:0]                 m, n, p;
  logic [7:0]                 in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [31:0][62:0][7:0]     matrixDataA, expA;
  logic [62:0][31:0][7:0]     matrixDataB, expB;
  logic                       ops_valid;
  logic                       consumed;
  logic                       busy;
  logic                       err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int startCyc, lastAccCyc;
  logic opsBefore;
  int elems[$];

  matmul_operand_loader #(.BITS(8), .DIM(32)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .n(n), .p(p),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .matrixDataA(matrixDataA), .matrixDataB(matrixDataB),
    .ops_valid(ops_valid), .consumed(consumed), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Element i of A sits at row i/n, column i%n; skew shifts row r right by r.
  // Element i of B sits at row i/p, column i%p; skew shifts column j down by j.
  function automatic void buildExp(input int mm, input int nn, input int pp);
    expA = '0;
    expB = '0;
    for (int i = 0; i < mm * nn; i++)
      expA[i / nn][i / nn + i % nn] = 8'(elems[i]);
    for (int i = 0; i < nn * pp; i++)
      expB[i / pp + i % pp][i % pp] = 8'(elems[mm * nn + i]);
  endfunction

  function automatic string diffA();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 63; c++)
        if (matrixDataA[r][c] !== expA[r][c])
          return $sformatf("A[%0d][%0d] actual=%0d required=%0d", r, c, matrixDataA[r][c], expA[r][c]);
    return "no entry differs";
  endfunction

  function automatic string diffB();
    for (int r = 0; r < 63; r++)
      for (int c = 0; c < 32; c++)
        if (matrixDataB[r][c] !== expB[r][c])
          return $sformatf("B[%0d][%0d] actual=%0d required=%0d", r, c, matrixDataB[r][c], expB[r][c]);
    return "no entry differs";
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prepRandom(input int mm, input int nn, input int pp);
    elems.delete();
    for (int i = 0; i < mm * nn + nn * pp; i++) elems.push_back(int'($urandom_range(1, 255)));
    buildExp(mm, nn, pp);
  endtask

  task automatic prepSeq(input int mm, input int nn, input int pp);
    elems.delete();
    for (int i = 0; i < mm * nn + nn * pp; i++) elems.push_back(i + 1);
    buildExp(mm, nn, pp);
  endtask

  task automatic doStart(input int mm, input int nn, input int pp);
    m = 6'(mm);
    n = 6'(nn);
    p = 6'(pp);
    start = 1'b1;
    tick();
    start = 1'b0;
    startCyc = cyc;
  endtask

  task automatic feed(input int first, input int count, input int maxGap);
    for (int i = first; i < first + count; i++) begin
      int gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      int w = 0;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      while (!in_ready && w < 20) begin
        tick();
        w++;
      end
      if (!in_ready) begin
        checks++;
        failures++;
        $display("FAIL feed_timeout element=%0d in_ready actual=0 required=1", i);
        return;
      end
      in_valid = 1'b1;
      in_data = 8'(elems[i]);
      opsBefore = ops_valid;
      tick();
      lastAccCyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    consumed = 1'b1;
    tick();
    consumed = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({in_ready, ops_valid, busy, err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl actual=%b required=0000", {in_ready, ops_valid, busy, err});
    end
    checks++;
    if (matrixDataA !== '0) begin failures++; $display("FAIL reset_A %s", diffA()); end
    checks++;
    if (matrixDataB !== '0) begin failures++; $display("FAIL reset_B %s", diffB()); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    prepSeq(2, 2, 2);
    doStart(2, 2, 2);
    checks++;
    if ({busy, in_ready, ops_valid} !== 3'b110) begin
      failures++;
      $display("FAIL nominal_after_start actual=%b required=110", {busy, in_ready, ops_valid});
    end
    feed(0, 8, 0);
    checks++;
    if (opsBefore !== 1'b0) begin failures++; $display("FAIL nominal_ops_early actual=%b required=0", opsBefore); end
    checks++;
    if (ops_valid !== 1'b1) begin failures++; $display("FAIL nominal_ops_valid actual=%b required=1", ops_valid); end
    checks++;
    if (lastAccCyc - startCyc !== 8) begin
      failures++;
      $display("FAIL nominal_latency actual=%0d required=8", lastAccCyc - startCyc);
    end
    checks++;
    if (matrixDataA !== expA) begin failures++; $display("FAIL nominal_A %s", diffA()); end
    checks++;
    if (matrixDataB !== expB) begin failures++; $display("FAIL nominal_B %s", diffB()); end
    checks++;
    if ({matrixDataA[0][0], matrixDataA[0][1], matrixDataA[1][1], matrixDataA[1][2]} !== 32'h01020304) begin
      failures++;
      $display("FAIL nominal_A_spots actual=%h required=01020304",
               {matrixDataA[0][0], matrixDataA[0][1], matrixDataA[1][1], matrixDataA[1][2]});
    end
    checks++;
    if ({matrixDataB[0][0], matrixDataB[1][1], matrixDataB[1][0], matrixDataB[2][1]} !== 32'h05060708) begin
      failures++;
      $display("FAIL nominal_B_spots actual=%h required=05060708",
               {matrixDataB[0][0], matrixDataB[1][1], matrixDataB[1][0], matrixDataB[2][1]});
    end
    consume();
    checks++;
    if ({ops_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL nominal_consume actual=%b required=00", {ops_valid, busy});
    end
    checks++;
    if (matrixDataA !== expA) begin failures++; $display("FAIL nominal_idle_hold %s", diffA()); end
  endtask

  task automatic test_backpressure();
    prepSeq(2, 2, 2);
    doStart(2, 2, 2);
    feed(0, 8, 3);
    checks++;
    if (ops_valid !== 1'b1) begin failures++; $display("FAIL bp_ops_valid actual=%b required=1", ops_valid); end
    checks++;
    if (matrixDataA !== expA) begin failures++; $display("FAIL bp_A %s", diffA()); end
    checks++;
    if (matrixDataB !== expB) begin failures++; $display("FAIL bp_B %s", diffB()); end
    consume();
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      int mm = int'($urandom_range(1, 8));
      int nn = int'($urandom_range(1, 8));
      int pp = int'($urandom_range(1, 8));
      prepRandom(mm, nn, pp);
      doStart(mm, nn, pp);
      checks++;
      if (matrixDataA !== '0 || matrixDataB !== '0) begin
        failures++;
        $display("FAIL rand_cleared_on_start %s", diffA());
      end
      feed(0, mm * nn + nn * pp, 2);
      checks++;
      if (matrixDataA !== expA) begin failures++; $display("FAIL rand_A m=%0d n=%0d p=%0d %s", mm, nn, pp, diffA()); end
      checks++;
      if (matrixDataB !== expB) begin failures++; $display("FAIL rand_B m=%0d n=%0d p=%0d %s", mm, nn, pp, diffB()); end
      consume();
    end
  endtask

  task automatic test_corner();
    prepSeq(1, 32, 1);
    doStart(1, 32, 1);
    feed(0, 64, 0);
    checks++;
    if (matrixDataA !== expA) begin failures++; $display("FAIL corner_1x32_A %s", diffA()); end
    checks++;
    if (matrixDataB !== expB) begin failures++; $display("FAIL corner_1x32_B %s", diffB()); end
    checks++;
    if ({matrixDataA[0][31], matrixDataB[31][0]} !== {8'd32, 8'd64}) begin
      failures++;
      $display("FAIL corner_1x32_spots actual=%h required=2040", {matrixDataA[0][31], matrixDataB[31][0]});
    end
    consume();
    prepRandom(32, 32, 32);
    doStart(32, 32, 32);
    feed(0, 2048, 0);
    checks++;
    if (lastAccCyc - startCyc !== 2048 || ops_valid !== 1'b1) begin
      failures++;
      $display("FAIL corner_32_latency actual=%0d ops=%b required=2048 ops=1", lastAccCyc - startCyc, ops_valid);
    end
    checks++;
    if (matrixDataA[31][62] !== 8'(elems[1023])) begin
      failures++;
      $display("FAIL corner_32_A_last actual=%0d required=%0d", matrixDataA[31][62], elems[1023]);
    end
    checks++;
    if (matrixDataA !== expA) begin failures++; $display("FAIL corner_32_A %s", diffA()); end
    checks++;
    if (matrixDataB !== expB) begin failures++; $display("FAIL corner_32_B %s", diffB()); end
    consume();
  endtask

  task automatic test_illegal();
    int bad[2][3] = '{'{2, 0, 2}, '{33, 2, 2}};
    for (int t = 0; t < 2; t++) begin
      doStart(bad[t][0], bad[t][1], bad[t][2]);
      checks++;
      if ({err, busy} !== 2'b10) begin
        failures++;
        $display("FAIL illegal_%0d_pulse err,busy actual=%b required=10", t, {err, busy});
      end
      tick();
      checks++;
      if ({err, busy} !== 2'b00) begin
        failures++;
        $display("FAIL illegal_%0d_after err,busy actual=%b required=00", t, {err, busy});
      end
      checks++;
      if (matrixDataA !== expA || matrixDataB !== expB) begin
        failures++;
        $display("FAIL illegal_%0d_arrays %s / %s", t, diffA(), diffB());
      end
    end
  endtask

  task automatic test_midreset();
    prepRandom(2, 2, 2);
    doStart(2, 2, 2);
    feed(0, 3, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, in_ready, ops_valid} !== 3'b000) begin
      failures++;
      $display("FAIL midreset_ctrl actual=%b required=000", {busy, in_ready, ops_valid});
    end
    checks++;
    if (matrixDataA !== '0 || matrixDataB !== '0) begin
      failures++;
      $display("FAIL midreset_arrays A:%s", diffA());
    end
  endtask

  task automatic test_ignored();
    prepRandom(2, 2, 2);
    doStart(2, 2, 2);
    consumed = 1'b1;
    feed(0, 2, 0);
    consumed = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL ign_consumed_in_load actual=%b required=11", {busy, in_ready});
    end
    feed(2, 6, 1);
    checks++;
    if (matrixDataA !== expA || matrixDataB !== expB) begin
      failures++;
      $display("FAIL ign_arrays %s / %s", diffA(), diffB());
    end
    doStart(3, 3, 3);
    checks++;
    if ({ops_valid, busy, in_ready} !== 3'b110) begin
      failures++;
      $display("FAIL ign_start_in_hold actual=%b required=110", {ops_valid, busy, in_ready});
    end
    checks++;
    if (matrixDataA !== expA || matrixDataB !== expB) begin
      failures++;
      $display("FAIL ign_hold_frozen %s / %s", diffA(), diffB());
    end
    consumed = 1'b1;
    doStart(3, 3, 3);
    consumed = 1'b0;
    checks++;
    if ({ops_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL ign_start_with_consumed actual=%b required=00", {ops_valid, busy});
    end
    prepRandom(1, 2, 3);
    doStart(1, 2, 3);
    checks++;
    if (busy !== 1'b1 || matrixDataA !== '0 || matrixDataB !== '0) begin
      failures++;
      $display("FAIL ign_restart busy actual=%b required=1, %s", busy, diffA());
    end
    feed(0, 8, 0);
    checks++;
    if (matrixDataA !== expA || matrixDataB !== expB) begin
      failures++;
      $display("FAIL ign_restart_arrays %s / %s", diffA(), diffB());
    end
    consume();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    m = '0;
    n = '0;
    p = '0;
    in_data = '0;
    in_valid = 1'b0;
    consumed = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_random();
    test_corner();
    test_illegal();
    test_midreset();
    test_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_operand_loader.md
# matmul_operand_loader

Upstream feeder for the MATMUL systolic stage. Accepts operand matrices A (m×n) and B (n×p) as a row-major element stream with a valid/ready handshake, and writes them into skewed, zero-padded register arrays. These arrays drive MATMUL's `matrixDataA` / `matrixDataB` inputs directly. It holds the loaded operands stable and flags them valid until the downstream controller acknowledges consumption.

## Interface

Parameters:
- `BITS`, 8, width of one matrix element.
- `DIM`, 32, maximum matrix dimension; skewed axis length is `DIM*2-1`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; dimensions sampled on the accepting cycle.
- `m`, `n`, `p`  in  `$clog2(DIM)+1` each  dimensions: A is m×n, B is n×p.
- `in_data`  in  BITS  stream element.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts an element this cycle.
- `matrixDataA`  out  `[DIM-1:0][DIM*2-2:0]` × BITS  skewed A.
- `matrixDataB`  out  `[DIM*2-2:0][DIM-1:0]` × BITS  skewed B.
- `ops_valid`  out  1  operands complete and stable.
- `consumed`  in  1  downstream done with operands.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  one-cycle pulse: start rejected for illegal dimensions.

## Operation

- FSM states: IDLE, LOAD_A, LOAD_B, HOLD.
- IDLE + `start`:
  - If any of m, n, p is 0 or greater than DIM: pulse `err` on the next cycle and stay in IDLE.
  - Otherwise: latch m, n, p, clear every entry of both arrays to 0, clear counters `r` and `c`, and go to LOAD_A.
- LOAD_A:
  - Each accepted element (`in_valid && in_ready`) is written as `matrixDataA[r][r+c] = in_data`.
  - `c` increments; when `c == n-1` it wraps to 0 and `r` increments.
  - The element at r = m-1, c = n-1 clears both counters and moves the FSM to LOAD_B.
- LOAD_B:
  - Each accepted element (counters k, j) is written as `matrixDataB[k+j][j] = in_data`.
  - `j` wraps at p-1, then `k` increments.
  - The element at k = n-1, j = p-1 moves the FSM to HOLD.
- HOLD: `ops_valid` = 1 and arrays are frozen. `consumed` returns the FSM to IDLE.
- Arrays keep their contents in IDLE and are cleared only by the next accepted start or by reset.
- Entries outside the written positions are always 0.
- `in_ready` = 1 exactly in LOAD_A and LOAD_B. An element offered with `in_valid` = 0 is not consumed and counters hold.
- Ignored inputs:
  - `start` in any non-IDLE state.
  - `consumed` outside HOLD.
  - `in_valid` in IDLE or HOLD.
- Index arithmetic uses `$clog2(DIM)+1`-bit counters. Maximum write index is `2*DIM-2`, which never overflows.

## Timing

- Reset (`rst` high at an edge) forces:
  - State = IDLE.
  - Every array entry = 0.
  - Counters and latched dimensions = 0.
  - `in_ready` = 0, `ops_valid` = 0, `busy` = 0, `err` = 0.
- Reset during LOAD or HOLD aborts the load with the same result; no partial data remains.
- `start` sampled at edge T: state is LOAD_A and `in_ready` = 1 from T+1, and the arrays read 0 from T+1.
- Each accepted element is visible on its array output one cycle after the accepting edge.
- With `in_valid` held high, the last B element is accepted at edge T+m·n+n·p. `ops_valid` rises at that edge (visible in the following cycle).
- The A→B transition costs no extra cycle: the first B element may be accepted on the cycle right after the last A element.
- `consumed` sampled at edge H: `ops_valid` = 0 and `busy` = 0 from H+1.
- A new `start` at H+1 is accepted.
- `start` and `consumed` asserted together while in HOLD: only `consumed` acts; `start` is ignored.
- `err` is high for exactly one cycle after the rejecting edge.

## Test plan

- **Reset:** assert `rst` for 2 cycles → all outputs 0 and every array entry 0.
- **Nominal 2×2:** m = n = p = 2, stream 1,2,3,4 then 5,6,7,8 with `in_valid` held high → `ops_valid` after 8 accepts. Expected nonzero entries:
  - `matrixDataA[0][0]`=1, `[0][1]`=2, `[1][1]`=3, `[1][2]`=4.
  - `matrixDataB[0][0]`=5, `[1][1]`=6, `[1][0]`=7, `[2][1]`=8.
  - All other entries 0.
- **Backpressure gaps:** same data as the nominal case, with `in_valid` deasserted for random 0–3 cycle gaps → identical arrays. Counters do not advance during gaps.
- **Corner dimensions:**
  - m = 1, n = 32, p = 1 with elements 1..64 → `matrixDataA[0][c]` = c+1, and B lands at `matrixDataB[k][0]`.
  - m = n = p = 32 → `matrixDataA[31][62]` = last A element.
- **Illegal start:** start with n = 0, then with m = 33 → `err` pulses once each, `busy` stays 0, arrays unchanged.
- **Mid-load reset and ignored controls:**
  - Reset after 3 of 8 accepts → arrays 0 and state IDLE.
  - `start` during HOLD ignored.
  - `consumed` in LOAD_A ignored.
  - Stale arrays cleared to 0 on the next valid start.
